rca_frame_accumulator: RTL

- Sequential stage placed directly upstream of the N-bit ripple_carry_adder. It feeds the adder's A, B and Cin inputs and registers the adder's SUM and Cout outputs.
- Accepts a stream of N-bit operands over a valid/ready handshake and accumulates up to MAX_OPS operands per frame.
- Presents the frame total, a sticky carry-out flag and an operand count over a valid/ready output handshake.
- All arithmetic goes through one internal ripple_carry_adder #(N) instance: A = acc register, B = in_data, Cin = 0.

---
 rtl/rca_frame_accumulator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rca_frame_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : rca_frame_accumulator (with ripple_carry_adder)
// Purpose  : Accumulates a frame of up to MAX_OPS operands through a single
//            N-bit ripple-carry adder. It reports the frame sum, a sticky
//            carry-out and the operand count over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================

// Plain N-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] carry_chain;

   assign carry_chain[0] = cin;

   generate
      for (genvar i = 0; i < N; i++) begin : g_bit
         assign sum[i]           = a[i] ^ b[i] ^ carry_chain[i];
         assign carry_chain[i+1] = (a[i] & b[i]) | (carry_chain[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout = carry_chain[N];

endmodule

module rca_frame_accumulator #(
   parameter int N       = 4,
   parameter int MAX_OPS = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N-1:0]                   in_data,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [N-1:0]                   out_sum,
   output logic                           out_carry,
   output logic [$clog2(MAX_OPS+1)-1:0]   out_count
);

   localparam int            CW      = $clog2(MAX_OPS + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPS);
   localparam logic [CW-1:0] ONE_CNT = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  acc, acc_nxt;
   logic          carry, carry_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   logic [N-1:0]  add_a;
   logic [N-1:0]  add_sum;
   logic          add_cout;
   logic [CW-1:0] cnt_inc;
   logic          accept;

   // The first operand of a frame is added to zero so a stale total never leaks in.
   assign add_a = (state == ACCUM) ? acc : '0;

   ripple_carry_adder #(.N(N)) u_adder (
      .a    (add_a),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // in_ready depends on state only, and is forced low while reset is held.
   assign in_ready  = rst_n && (state != DONE);
   assign accept    = in_valid && in_ready;
   assign cnt_inc   = cnt + ONE_CNT;

   // Results come straight from the registers, so there is no path from in_* to out_*.
   assign out_valid = (state == DONE);
   assign out_sum   = acc;
   assign out_carry = carry;
   assign out_count = cnt;

   // Next-state and datapath update decode.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      carry_nxt = carry;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               acc_nxt   = add_sum;
               carry_nxt = 1'b0;
               cnt_nxt   = ONE_CNT;
               if (in_last || (MAX_OPS == 1)) state_nxt = DONE;
               else                           state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_nxt   = add_sum;
               carry_nxt = carry | add_cout;
               cnt_nxt   = cnt_inc;
               if (in_last || (cnt_inc == MAX_CNT)) state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
               acc_nxt   = '0;
               carry_nxt = 1'b0;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            carry_nxt = 1'b0;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and accumulator registers; reset drops any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         carry <= carry_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule
`default_nettype wire
